// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller. It turns an EX/MEM load or store into a
// request/done handshake with a stalling data memory. While the access is in
// flight it freezes the front of the pipeline. When the access finishes it hands
// the load data and a one-cycle completion strobe to MEM/WB. It also parks the
// pipeline on HALT and raises a sticky error on illegal or timed-out accesses.
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        halt_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic [15:0] read_data_out,
    output logic        wb_valid_out,
    output logic        stall_out,
    output logic        halt_out,
    output logic        err_out
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          op_read_q, op_read_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;

    // Next-state, latch updates and the combinational stall/writeback strobes
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        op_read_d    = op_read_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        halt_d       = halt_q;
        err_d        = err_q;
        stall_out    = 1'b0;
        wb_valid_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (halt_in) begin
                        state_d = S_HALTED;
                        halt_d  = 1'b1;
                    end else if (mem_read_in && mem_write_in) begin
                        err_d        = 1'b1;
                        wb_valid_out = 1'b1;
                    end else if ((mem_read_in || mem_write_in) && addr_in[0]) begin
                        err_d        = 1'b1;
                        wb_valid_out = 1'b1;
                    end else if (mem_read_in || mem_write_in) begin
                        op_read_d = mem_read_in;
                        mem_rd_d  = mem_read_in;
                        mem_wr_d  = mem_write_in;
                        addr_d    = addr_in;
                        wdata_d   = wdata_in;
                        stall_out = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        wb_valid_out = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall_out = 1'b1;
                if (!mem_stall) begin
                    mem_rd_d   = 1'b0;
                    mem_wr_d   = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_out = 1'b1;
                if (mem_done) begin
                    if (op_read_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
                    err_d = 1'b1;
                    if (op_read_q) begin
                        rdata_d = 16'h0000;
                    end
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                wb_valid_out = 1'b1;
                state_d      = S_IDLE;
            end
            S_HALTED: begin
                stall_out = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            op_read_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rdata_q    <= 16'h0000;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_read_q  <= op_read_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
        end
    end

    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign read_data_out = rdata_q;
    assign halt_out      = halt_q;
    assign err_out       = err_q;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store held in EX/MEM into a request/done transaction on a multi-cycle stalling data memory. While the access is outstanding it holds the front of the pipeline. When the access finishes it presents the captured load data and a one-cycle completion strobe to MEM/WB. It also drains HALT and flags illegal or timed-out accesses.

## Interface
- MAX_WAIT, default 15: number of WAIT-state cycles without mem_done before the access is abandoned.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX/MEM holds a valid instruction this cycle.
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- halt_in  in  1  instruction is HALT.
- addr_in  in  16  byte address from the ALU result.
- wdata_in  in  16  store data.
- mem_rd  out  1  read request to data memory.
- mem_wr  out  1  write request to data memory.
- mem_addr  out  16  latched request address.
- mem_wdata  out  16  latched store data.
- mem_stall  in  1  memory cannot accept a request this cycle.
- mem_done  in  1  access complete; mem_rdata is valid for reads.
- mem_rdata  in  16  read data.
- read_data_out  out  16  captured load data, fed to the MEM/WB read_data input.
- wb_valid_out  out  1  instruction leaves the MEM stage this cycle; ANDed into the reg_write written to MEM/WB.
- stall_out  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (their en = ~stall_out).
- halt_out  out  1  HALT has drained; goes to the MEM/WB halt input.
- err_out  out  1  sticky error flag.

## Operation
- States: IDLE, REQ, WAIT, DONE, HALTED. Encoding is free.
- IDLE behaviour is decided by the first matching condition below.
  - req_valid=0: no action; stall_out=0, wb_valid_out=0.
  - req_valid & halt_in: go to HALTED. No memory access occurs, even if a read or write bit is also set.
  - req_valid & mem_read_in & mem_write_in: err_out<=1; no access; wb_valid_out=1, stall_out=0.
  - req_valid & (rd|wr) & addr_in[0]=1 (unaligned word): err_out<=1; no access; wb_valid_out=1, stall_out=0.
  - req_valid & (rd|wr), aligned: latch op, addr and wdata; stall_out=1 (combinational, same cycle); go to REQ.
  - req_valid, no memory operation: wb_valid_out=1, stall_out=0; stay in IDLE.
- REQ: drive mem_rd or mem_wr from the latched op, with mem_addr and mem_wdata from the latches; stall_out=1.
  - mem_stall=1: stay in REQ and keep the request asserted.
  - mem_stall=0: the request is accepted; go to WAIT and clear wait_cnt to 0.
- WAIT: mem_rd and mem_wr are low; stall_out=1.
  - mem_done=1: for a read, read_data_out<=mem_rdata; go to DONE.
  - mem_done=0: wait_cnt increments.
  - wait_cnt reaching MAX_WAIT-1 with no done: err_out<=1, read_data_out<=16'h0000, go to DONE.
- DONE: stall_out=0, wb_valid_out=1; return to IDLE. The pipeline advances on this edge, so no access is re-issued.
- Stores leave read_data_out unchanged.
- HALTED: stall_out=1, halt_out=1, wb_valid_out=0. Only rst exits this state.
- err_out is sticky and is cleared only by rst.
- mem_done arriving in any state other than WAIT is ignored.
- wait_cnt is wide enough to hold MAX_WAIT.

## Timing
- Reset values: state=IDLE; mem_rd=mem_wr=0; mem_addr=mem_wdata=0; read_data_out=0; wb_valid_out=0; stall_out=0; halt_out=0; err_out=0; wait_cnt=0.
- Reset mid-access returns to IDLE the following cycle. The request is dropped and no completion strobe is produced.
- mem_rd, mem_wr, mem_addr, mem_wdata, read_data_out and halt_out are registered outputs.
- stall_out and wb_valid_out are decoded from the state and the inputs.
- Request timing:
  - The request is visible one cycle after IDLE accepts the instruction.
  - It stays asserted for 1 + (number of mem_stall cycles).
- Load latency: an access with no memory stalls and mem_done N cycles after the REQ cycle (N≥1) holds stall_out high for N+2 cycles (IDLE, REQ, N−1 WAIT cycles, the done cycle).
  - The DONE cycle follows, with wb_valid_out=1 and read_data_out valid.
- Back-to-back memory instructions: IDLE re-evaluates on the cycle after DONE. There is a minimum of 1 non-stalled cycle between accesses.

## Test plan
- Load, addr 16'h0010, mem_stall=0, mem_done 3 cycles after REQ with mem_rdata=16'hBEEF -> mem_rd high for exactly 1 cycle; stall_out high for 5 cycles; then read_data_out=16'hBEEF with wb_valid_out=1 for 1 cycle.
- Store, addr 16'h0020, wdata 16'h1234, mem_stall=1 for 2 cycles -> mem_wr held 3 cycles with mem_addr=0020 and mem_wdata=1234; read_data_out unchanged; single wb_valid_out pulse.
- Load to addr 16'h0011 -> no mem_rd; err_out=1 next cycle; wb_valid_out=1 in the same cycle; stall_out never high.
- Load with mem_done never asserted, MAX_WAIT=15 -> err_out set after 15 WAIT cycles; DONE with read_data_out=0; next instruction proceeds.
- HALT after a pending store -> the store completes first; then halt_out=1 and stall_out=1 persist; rst clears both to 0.
- rst asserted during WAIT of a load -> next cycle all outputs are at reset values; a later mem_done is ignored; wb_valid_out stays 0.
